// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_rx_pkg;

  localparam int PRESCALE_W   = 6;
  localparam int BIT_CNT_W    = 4;
  localparam int PRESCALE_MIN = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    ERR_CHK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Bundle between the UART frame controller and its sampler/checker datapath.
// Latency: n/a (wires only). Optional err_cnt when UART_RX_ERR_CNT_EN is defined.
// Backpressure: none; the serial line cannot be stalled.
interface uart_rx_fsm_if;
  import uart_rx_pkg::*;

  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic                  par_en;
  logic                  par_err;
  logic                  strt_glitch;
  logic                  stp_err;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  dat_samp_en;
  logic                  deser_en;
  logic                  par_chk_en;
  logic                  strt_chk_en;
  logic                  stp_chk_en;
  logic                  data_valid;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0]            err_cnt;
`endif

  // Datapath / line side
  modport master (
    output rx_in, prescale, par_en, par_err, strt_glitch, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, deser_en, par_chk_en,
           strt_chk_en, stp_chk_en, data_valid
`ifdef UART_RX_ERR_CNT_EN
           , err_cnt
`endif
  );

  // Frame controller side
  modport slave (
    input  rx_in, prescale, par_en, par_err, strt_glitch, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, deser_en, par_chk_en,
           strt_chk_en, stp_chk_en, data_valid
`ifdef UART_RX_ERR_CNT_EN
           , err_cnt
`endif
  );

endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and frame bit counter; edge wraps at presc-1 and bumps bit.
// Latency: counters update one clk after en; clear has priority over en.
// Backpressure: none; en simply freezes both counters.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic [PRESCALE_W-1:0] i_presc,
  output logic [PRESCALE_W-1:0] o_edge_cnt,
  output logic [BIT_CNT_W-1:0]  o_bit_cnt,
  output logic                  o_bit_end
);

  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  w_bit_end;

  assign w_bit_end  = (r_edge_cnt == (i_presc - PRESCALE_W'(1)));
  assign o_edge_cnt = r_edge_cnt;
  assign o_bit_cnt  = r_bit_cnt;
  assign o_bit_end  = w_bit_end;

  // Count oversample edges; at the last edge of a bit wrap and advance the bit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_clr) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_en) begin
      if (w_bit_end) begin
        r_edge_cnt <= '0;
        r_bit_cnt  <= r_bit_cnt + BIT_CNT_W'(1);
      end else begin
        r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start detect, bit sequencing, one-cycle data_valid per good frame.
// Latency: data_valid presc*(DATA_WIDTH+2+par_en)+1 clks after first low rx_in; UART_RX_ERR_CNT_EN adds err_cnt.
// Backpressure: none; back-to-back frames restart directly from ERR_CHK.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  uart_rx_fsm_if.slave bus
);

  rx_state_e             r_state;
  rx_state_e             w_state_nxt;
  logic [PRESCALE_W-1:0] r_presc_q;
  logic                  r_par_en_q;
  logic                  w_load;
  logic                  w_cnt_en;
  logic                  w_cnt_clr;
  logic                  w_bit_end;
  logic [PRESCALE_W-1:0] w_edge_cnt;
  logic [BIT_CNT_W-1:0]  w_bit_cnt;
  logic                  w_samp_en;
  logic                  w_deser_en;
  logic                  w_par_chk_en;
  logic                  w_strt_chk_en;
  logic                  w_stp_chk_en;
  logic                  w_data_valid;

  // A new frame begins whenever we enter START from anywhere else
  assign w_load    = (w_state_nxt == START) && (r_state != START);
  assign w_cnt_clr = (w_state_nxt == IDLE) || w_load;
  assign w_cnt_en  = (r_state != IDLE) && (r_state != ERR_CHK);

  uart_rx_edge_bit_cnt u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_cnt_en),
    .i_clr      (w_cnt_clr),
    .i_presc    (r_presc_q),
    .o_edge_cnt (w_edge_cnt),
    .o_bit_cnt  (w_bit_cnt),
    .o_bit_end  (w_bit_end)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Freeze frame configuration at the start of each frame so mid-frame changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc_q  <= PRESCALE_W'(PRESCALE_MIN);
      r_par_en_q <= 1'b0;
    end else if (w_load) begin
      r_presc_q  <= bus.prescale;
      r_par_en_q <= bus.par_en;
    end
  end

  // Next-state and per-state enables
  always_comb begin
    w_state_nxt   = r_state;
    w_samp_en     = 1'b0;
    w_deser_en    = 1'b0;
    w_par_chk_en  = 1'b0;
    w_strt_chk_en = 1'b0;
    w_stp_chk_en  = 1'b0;
    w_data_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!bus.rx_in) w_state_nxt = START;
      end
      START: begin
        w_samp_en     = 1'b1;
        w_strt_chk_en = 1'b1;
        if (w_bit_end) w_state_nxt = bus.strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        w_samp_en  = 1'b1;
        w_deser_en = 1'b1;
        if (w_bit_end && (w_bit_cnt == BIT_CNT_W'(DATA_WIDTH)))
          w_state_nxt = r_par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        w_samp_en    = 1'b1;
        w_par_chk_en = 1'b1;
        if (w_bit_end) w_state_nxt = STOP;
      end
      STOP: begin
        w_samp_en    = 1'b1;
        w_stp_chk_en = 1'b1;
        if (w_bit_end) w_state_nxt = ERR_CHK;
      end
      ERR_CHK: begin
        w_data_valid = !bus.stp_err && !(r_par_en_q && bus.par_err);
        w_state_nxt  = bus.rx_in ? IDLE : START;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.edge_cnt    = w_edge_cnt;
  assign bus.bit_cnt     = w_bit_cnt;
  assign bus.dat_samp_en = w_samp_en;
  assign bus.deser_en    = w_deser_en;
  assign bus.par_chk_en  = w_par_chk_en;
  assign bus.strt_chk_en = w_strt_chk_en;
  assign bus.stp_chk_en  = w_stp_chk_en;
  assign bus.data_valid  = w_data_valid;

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;
  logic       w_err_evt;

  assign w_err_evt = ((r_state == ERR_CHK) && (bus.stp_err || (r_par_en_q && bus.par_err))) ||
                     ((r_state == START) && w_bit_end && bus.strt_glitch);

  // Saturating count of bad frames, including aborted start bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_err_cnt <= '0;
    else if (w_err_evt && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign bus.err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: directed plus random frames against a frame-level model.
// Latency: per-cycle expectations derived from bit/edge arithmetic of each frame.
// Backpressure: n/a.
module tb_uart_rx_fsm;
  import uart_rx_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_fsm_if bus ();

  uart_rx_fsm #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         p;
    bit         pe;
    logic [7:0] d;
    bit         perr;
    bit         serr;
    bit         glitch;
    bit         b2b;
    int         gap;
  } frame_t;

  int     n_vec = 0;
  int     n_bad = 0;
  int     m_err = 0;
  frame_t fq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rand_psc();
    case ($urandom_range(0, 2))
      0:       return 8;
      1:       return 16;
      default: return 32;
    endcase
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic frame_t mk(int p, bit pe, logic [7:0] d, bit perr, bit serr,
                                bit glitch, bit b2b, int gap);
    frame_t f;
    f.p = p; f.pe = pe; f.d = d; f.perr = perr; f.serr = serr;
    f.glitch = glitch; f.b2b = b2b; f.gap = gap;
    return f;
  endfunction

  task automatic drive(input logic rx, input int psc, input bit pe, input bit perr,
                       input bit sg, input bit serr);
    bus.rx_in       = rx;
    bus.prescale    = PRESCALE_W'(psc);
    bus.par_en      = pe;
    bus.par_err     = perr;
    bus.strt_glitch = sg;
    bus.stp_err     = serr;
  endtask

  // en_exp = {samp, deser, par, strt, stp, data_valid}
  task automatic expect_out(input string ph, input logic [5:0] en_exp, input int e,
                            input int b, input bit chk_cnt);
    logic [5:0] en_got;
    en_got = {bus.dat_samp_en, bus.deser_en, bus.par_chk_en,
              bus.strt_chk_en, bus.stp_chk_en, bus.data_valid};
    check({ph, ".en"}, 32'(en_got), 32'(en_exp));
    if (chk_cnt) begin
      check({ph, ".edge"}, 32'(bus.edge_cnt), e);
      check({ph, ".bit"}, 32'(bus.bit_cnt), b);
    end
`ifdef UART_RX_ERR_CNT_EN
    check({ph, ".err_cnt"}, 32'(bus.err_cnt), m_err);
`endif
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input frame_t f, input frame_t nf, input bit started);
    int          n;
    int          last;
    int          deser;
    logic [10:0] ln;
    logic [5:0]  en;
    logic        rx;
    bit          sg;
    bit          dv;
    n     = 10 + int'(f.pe);
    deser = 0;
    ln    = '1;
    ln[0] = 1'b0;
    ln[8:1] = f.d;
    if (f.pe) ln[9] = ^f.d;
    if (!started) begin
      drive(1'b0, f.p, f.pe, rb(), rb(), rb());
      @(negedge clk);
      expect_out("idle0", 6'b0, 0, 0, 1'b1);
      next_cyc();
    end
    last = f.glitch ? f.p : n * f.p;
    for (int k = 1; k <= last; k++) begin
      int bi;
      int e;
      bi = (k - 1) / f.p;
      e  = (k - 1) % f.p;
      if (f.glitch) rx = (k < 3) ? 1'b0 : 1'b1;
      else          rx = (k / f.p < n) ? ln[k / f.p] : 1'b1;
      sg = (k == f.p) ? f.glitch : rb();
      drive(rx, rand_psc(), rb(), rb(), sg, rb());
      if (bi == 0)                en = 6'b100100;
      else if (bi <= 8)           en = 6'b110000;
      else if (f.pe && bi == 9)   en = 6'b101000;
      else                        en = 6'b100010;
      @(negedge clk);
      expect_out("frame", en, e, bi, 1'b1);
      if (bus.deser_en) deser++;
      next_cyc();
    end
    if (f.glitch) begin
      m_err = (m_err < 255) ? m_err + 1 : 255;
      check("glitch.deser_cycles", deser, 0);
    end else begin
      drive(f.b2b ? 1'b0 : 1'b1, f.b2b ? nf.p : rand_psc(), f.b2b ? nf.pe : rb(),
            f.perr, rb(), f.serr);
      dv = !f.serr && !(f.pe && f.perr);
      @(negedge clk);
      expect_out("errchk", {5'b0, dv}, 0, 0, 1'b0);
      check("deser_cycles", deser, 8 * f.p);
      if (!dv) m_err = (m_err < 255) ? m_err + 1 : 255;
      next_cyc();
    end
    if (!(f.b2b && !f.glitch)) begin
      for (int g = 0; g < f.gap; g++) begin
        drive(1'b1, rand_psc(), rb(), rb(), rb(), rb());
        @(negedge clk);
        expect_out("idle", 6'b0, 0, 0, 1'b1);
        next_cyc();
      end
    end
  endtask

  task automatic run_queue();
    bit     started;
    frame_t f;
    frame_t nf;
    started = 1'b0;
    for (int i = 0; i < fq.size(); i++) begin
      f = fq[i];
      if (i + 1 < fq.size()) nf = fq[i + 1];
      else begin
        nf = f;
        f.b2b = 1'b0;
      end
      if (f.glitch) f.b2b = 1'b0;
      run_frame(f, nf, started);
      started = f.b2b;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    expect_out("reset", 6'b0, 0, 0, 1'b1);
    next_cyc();
    rst = 1'b0;

    // Directed frames: clean, parity ok, parity error, start glitch, back-to-back pair
    fq.push_back(mk(8,  1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 3));
    fq.push_back(mk(16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 2));
    fq.push_back(mk(16, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 2));
    fq.push_back(mk(8,  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2));
    fq.push_back(mk(8,  1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 0));
    fq.push_back(mk(8,  1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 2));
    fq.push_back(mk(32, 1'b0, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 2));
    run_queue();

    // Reset in DATA bit 4 with prescale moved to 16 mid-frame
    drive(1'b0, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("rst_idle0", 6'b0, 0, 0, 1'b1);
    next_cyc();
    for (int k = 1; k <= 36; k++) begin
      drive(rb(), (k > 10) ? 16 : 8, rb(), rb(), 1'b0, rb());
      if (k < 36) next_cyc();
    end
    check("pre_rst.bit", 32'(bus.bit_cnt), 4);
    check("pre_rst.deser", 32'(bus.deser_en), 1);
    #1;
    rst = 1'b1;
    m_err = 0;
    #1;
    expect_out("rst_async", 6'b0, 0, 0, 1'b1);
    next_cyc();
    drive(1'b1, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      expect_out("post_rst", 6'b0, 0, 0, 1'b1);
      next_cyc();
      drive(1'b1, 16, rb(), rb(), rb(), rb());
    end

    // New prescale only after a new start, then random traffic
    fq.delete();
    fq.push_back(mk(16, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1));
    for (int i = 0; i < 30; i++) begin
      frame_t f;
      bit g;
      g = ($urandom_range(0, 7) == 0);
      f = mk(rand_psc(), rb(), 8'($urandom_range(0, 255)),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             g, g ? 1'b0 : rb(), $urandom_range(0, 4));
      fq.push_back(f);
    end
    run_queue();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
